// File: rtl/tick_sched_pkg.sv
// Shared defaults and config FSM state type for the tick scheduler.
package tick_sched_pkg;

    localparam int PRESCALE_DEF = 50000;
    localparam int NUM_CH_DEF   = 4;
    localparam int PERIOD_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/tick_sched_chan.sv
// One scheduled channel: period/enable registers, base-tick counter,
// tick pulse and square-wave toggle.
module tick_chan #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                base_tick,
    input  logic                set,
    input  logic [PERIOD_W-1:0] set_period,
    input  logic                set_en,
    output logic                tick,
    output logic                clk_out
);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] count;
    logic                en;
    logic                active;

    assign active = en && (period != '0);

    // A config write wins over a coincident base tick: that tick is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            period  <= '0;
            count   <= '0;
            en      <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (set) begin
            period  <= set_period;
            en      <= set_en;
            count   <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (base_tick && active) begin
                if (count == period - PERIOD_W'(1)) begin
                    count   <= '0;
                    tick    <= 1'b1;
                    clk_out <= ~clk_out;
                end else begin
                    count <= count + PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Prescaled base tick feeding NUM_CH programmable tick channels,
// configured through a two-state valid/ready write port.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_en,
    output logic                cfg_err,
    output logic                base_tick,
    output logic [NUM_CH-1:0]   tick_o,
    output logic [NUM_CH-1:0]   clk_o
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     ps_cnt;
    cfg_state_t          state;
    logic [CH_W-1:0]     ch_q;
    logic [PERIOD_W-1:0] period_q;
    logic                en_q;
    logic                apply;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt    <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= (ps_cnt == PS_LAST);
            ps_cnt    <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
        end
    end

    assign cfg_ready = !rst && (state == IDLE);
    assign apply     = (state == APPLY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ch_q     <= '0;
            period_q <= '0;
            en_q     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_err <= 1'b0;
                    if (cfg_valid) begin
                        ch_q     <= cfg_ch;
                        period_q <= cfg_period;
                        en_q     <= cfg_en;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    cfg_err <= en_q && (period_q == '0);
                    state   <= IDLE;
                end
                default: begin
                    cfg_err <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_chan #(
            .PERIOD_W(PERIOD_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .base_tick (base_tick),
            .set       (apply && (ch_q == CH_W'(i))),
            .set_period(period_q),
            .set_en    (en_q),
            .tick      (tick_o[i]),
            .clk_out   (clk_o[i])
        );
    end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with PRESCALE=4, NUM_CH=4, PERIOD_W=16.
module tb_tick_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_en;
    logic        cfg_err;
    logic        base_tick;
    logic [3:0]  tick_o;
    logic [3:0]  clk_o;

    int n_checks = 0;
    int n_fail   = 0;

    tick_sched #(
        .PRESCALE(4),
        .NUM_CH  (4),
        .PERIOD_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .base_tick (base_tick),
        .tick_o    (tick_o),
        .clk_o     (clk_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a base_tick cycle, bounded to two prescale periods.
    task automatic sync_base(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (base_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_cfg(input logic [1:0] ch, input logic [15:0] p,
                             input logic e);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_en     = e;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_period = '0;
        cfg_en    = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({tick_o, clk_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 00", {tick_o, clk_o});
        end
        n_checks++;
        if ({base_tick, cfg_err, cfg_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000",
                     {base_tick, cfg_err, cfg_ready});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", cfg_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (base_tick !== (i == 4)) begin
                n_fail++;
                $display("FAIL reset_base c%0d: got %b want %b",
                         i, base_tick, (i == 4));
            end
        end
    endtask

    task automatic test_ch0_period();
        bit ok;
        logic ex_t, ex_c;
        sync_base(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ch0_sync: got timeout want base_tick");
        end
        drive_cfg(2'd0, 16'd3, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) begin
                cfg_valid = 1'b0;
                n_checks++;
                if (cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ch0_ready: got %b want 0", cfg_ready);
                end
            end
            ex_t = (i == 13) || (i == 25) || (i == 37);
            ex_c = (i >= 13) ^ (i >= 25) ^ (i >= 37);
            n_checks++;
            if ({tick_o, clk_o[0]} !== {3'b000, ex_t, ex_c}) begin
                n_fail++;
                $display("FAIL ch0_tick c%0d: got tick=%b clk0=%b want tick=%b clk0=%b",
                         i, tick_o, clk_o[0], {3'b000, ex_t}, ex_c);
            end
        end
    endtask

    task automatic test_cfg_err();
        bit ok;
        int errs;
        errs = 0;
        sync_base(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL err_sync: got timeout want base_tick");
        end
        drive_cfg(2'd2, 16'd0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) cfg_valid = 1'b0;
            if (cfg_err === 1'b1) errs++;
            n_checks++;
            if (cfg_err !== (i == 2) || tick_o[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse c%0d: got err=%b tick2=%b want err=%b tick2=0",
                         i, cfg_err, tick_o[2], (i == 2));
            end
        end
        n_checks++;
        if (errs != 1) begin
            n_fail++;
            $display("FAIL err_count: got %0d want 1", errs);
        end
    endtask

    task automatic test_apply_vs_base();
        bit ok;
        sync_base(ok);
        drive_cfg(2'd1, 16'd1, 1'b1);
        step();
        cfg_valid = 1'b0;
        sync_base(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL coin_sync: got timeout want base_tick");
        end
        step();
        n_checks++;
        if (tick_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL coin_p1_tick: got %b want 1", tick_o[1]);
        end
        repeat (2) step();
        drive_cfg(2'd1, 16'd2, 1'b1);
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if ({base_tick, cfg_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL coin_align: got base=%b ready=%b want base=1 ready=0",
                     base_tick, cfg_ready);
        end
        for (int i = 5; i <= 13; i++) begin
            step();
            n_checks++;
            if (tick_o[1] !== (i == 13)) begin
                n_fail++;
                $display("FAIL coin_tick c%0d: got %b want %b",
                         i, tick_o[1], (i == 13));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] per[4] = '{16'd5, 16'd1, 16'd1, 16'd1};
        logic        ena[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int cnt[4] = '{0, 0, 0, 0};
        int want[4] = '{0, 1, 2, 0};
        int maxpop;
        maxpop = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cfg(2'(i), per[i], ena[i]);
            #1;
            n_checks++;
            if (cfg_ready !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready c%0d: got %b want %b",
                         i, cfg_ready, (i % 2 == 0));
            end
            step();
        end
        cfg_valid = 1'b0;
        sync_base(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_sync: got timeout want base_tick");
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            for (int c = 0; c < 4; c++) cnt[c] += int'(tick_o[c]);
            if ($countones(tick_o) > maxpop) maxpop = $countones(tick_o);
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (cnt[c] != want[c]) begin
                n_fail++;
                $display("FAIL b2b_ticks ch%0d: got %0d want %0d",
                         c, cnt[c], want[c]);
            end
        end
        n_checks++;
        if (maxpop != 2) begin
            n_fail++;
            $display("FAIL b2b_multi: got %0d want 2", maxpop);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        sync_base(ok);
        drive_cfg(2'd0, 16'd1, 1'b1);
        step();
        cfg_valid = 1'b0;
        sync_base(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstm_sync: got timeout want base_tick");
        end
        step();
        n_checks++;
        if ({tick_o[0], clk_o[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstm_pre: got tick0=%b clk0=%b want 1 1",
                     tick_o[0], clk_o[0]);
        end
        drive_cfg(2'd3, 16'd1, 1'b1);
        step();
        cfg_valid = 1'b0;
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstm_apply: got ready=%b want 0", cfg_ready);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({tick_o, clk_o, base_tick, cfg_err, cfg_ready} !== 11'd0) begin
            n_fail++;
            $display("FAIL rstm_clear: got tick=%b clk=%b base=%b err=%b ready=%b want all 0",
                     tick_o, clk_o, base_tick, cfg_err, cfg_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstm_ready: got %b want 1", cfg_ready);
        end
        for (int i = 1; i <= 24; i++) begin
            step();
            n_checks++;
            if ({tick_o, clk_o} !== 8'h00 || base_tick !== (i % 4 == 0)) begin
                n_fail++;
                $display("FAIL rstm_idle c%0d: got tick=%b clk=%b base=%b want 0 0 %b",
                         i, tick_o, clk_o, base_tick, (i % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ch0_period();
        test_cfg_err();
        test_apply_vs_base();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
